// File: rtl/sum_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sum_uart_pkg
//  Description : Shared definitions for the sum-latch UART (RX and TX side):
//                receiver FSM state encoding, frame geometry constants and
//                the clocks-per-bit helper.
//  Revision    : 1.0  initial release
// ============================================================================
package sum_uart_pkg;

    // Frame geometry shared with the transmitter: 1 start + 8 data + 1 stop.
    localparam int   FRAME_BITS = 10;
    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Clocks per bit period (integer division, truncating).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchroniser for a single asynchronous input.
//                Both flops reset to INIT so an idle-high line does not
//                produce a spurious edge when reset is released.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                i_d  - asynchronous input
//                o_q  - synchronised output (two clocks of latency)
//  Revision    : 1.0  initial release
// ============================================================================
module sync2 #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= INIT;
            r_sync <= INIT;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sum_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sum_uart_rx
//  Description : 8N1 UART receiver. Synchronises the serial line, detects a
//                start bit, samples each bit mid-period and emits the byte
//                with a one-cycle valid strobe. A low stop bit raises a
//                one-cycle framing-error strobe and the receiver then waits
//                for the line to return high before hunting for a new start.
//  Ports       : clk        - system clock
//                reset      - synchronous active-high reset
//                uart_rxd   - asynchronous serial input, idle high
//                rx_data    - last good byte, LSB = first data bit
//                rx_valid   - one-cycle pulse when rx_data is updated
//                frame_err  - one-cycle pulse when the stop bit samples low
//                rx_busy    - high whenever the receiver is not idle
//  Revision    : 1.0  initial release
// ============================================================================
module sum_uart_rx #(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    import sum_uart_pkg::*;

    localparam int N     = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Terminal counts: half a bit to reach mid-start, a full bit thereafter.
    localparam logic [CNT_W-1:0] c_HALF_M1 = CNT_W'(N / 2 - 1);
    localparam logic [CNT_W-1:0] c_FULL_M1 = CNT_W'(N - 1);
    localparam logic [2:0]       c_LAST_BIT = 3'(DATA_BITS - 1);

    generate
        if (N < 4) begin : g_bad_n
            $error("sum_uart_rx: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    logic                 w_rxd_s;
    rx_state_t            r_state,  w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic [2:0]           r_bit,    w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift,  w_shift_nxt;
    logic [DATA_BITS-1:0] r_data,   w_data_nxt;
    logic                 r_valid,  w_valid_nxt;
    logic                 r_ferr,   w_ferr_nxt;

    sync2 #(
        .INIT (IDLE_LEVEL)
    ) u_sync_rxd (
        .clk (clk),
        .rst (reset),
        .i_d (uart_rxd),
        .o_q (w_rxd_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (!w_rxd_s) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_nxt   = '0;
                    // A line that is high again at mid-start was a glitch.
                    w_state_nxt = w_rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rxd_s, r_shift[DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == c_LAST_BIT) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_nxt = '0;
                    if (w_rxd_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line idles so a stuck-low line is not
                // mistaken for a stream of zero bytes.
                w_cnt_nxt = '0;
                if (w_rxd_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign rx_busy   = (r_state != IDLE);

endmodule
`default_nettype wire
